// File: rtl/seg7_to_bin.sv
`default_nettype none
// ============================================================================
// Module      : seg7_to_bin
// Description : Debounced seven-segment pattern to 4-bit binary decoder with
//               a valid/ready output handshake. A segment pattern is accepted
//               once it has been constant for STABLE_CYCLES clock edges. A
//               pattern equal to the last one emitted is not emitted again.
//               An accepted result is held on the outputs until i_ready
//               takes it.
// Ports       : clk, rst (synchronous, active-high)
//               i_segment_A..i_segment_G : segment lines, {A..G} = bits 6..0
//               i_ready      : downstream accepts the presented result
//               o_valid      : a result is presented
//               o_binary_num : decoded value (0 for an illegal pattern)
//               o_invalid    : the accepted pattern is not a legal glyph
//               o_blank      : the accepted pattern is all-off
// Parameters  : STABLE_CYCLES (1..255, default 4)
// Macro       : SEG7_DEC_BLANK_EN - when defined, the all-off pattern is
//               legal and is reported through o_blank. When it is undefined,
//               the all-off pattern is reported as invalid and o_blank is
//               tied to 0.
// Revision    : 1.0 - initial release
// ============================================================================
module seg7_to_bin #(
  parameter int STABLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_segment_A,
  input  logic       i_segment_B,
  input  logic       i_segment_C,
  input  logic       i_segment_D,
  input  logic       i_segment_E,
  input  logic       i_segment_F,
  input  logic       i_segment_G,
  input  logic       i_ready,
  output logic       o_valid,
  output logic [3:0] o_binary_num,
  output logic       o_invalid,
  output logic       o_blank
);

  // The counter value seen at the accepting edge is STABLE_CYCLES-1. It
  // clears on the edge that captures the change.
  localparam logic [7:0] c_stable_thresh = 8'(STABLE_CYCLES - 1);

  typedef enum logic [1:0] {
    S_WAIT  = 2'd0,
    S_VALID = 2'd1,
    S_LOCK  = 2'd2
  } state_t;

  state_t     r_state;
  logic [6:0] r_sample;
  logic [7:0] r_count;
  logic [6:0] r_last;
  logic       r_emitted;
  logic       r_changed;   // input moved while a result was being presented

  logic [6:0] w_pattern;
  logic       w_diff;
  logic       w_stable;
  logic [3:0] w_dec_num;
  logic       w_dec_invalid;
  logic       w_dec_blank;

  assign w_pattern = {i_segment_A, i_segment_B, i_segment_C, i_segment_D,
                      i_segment_E, i_segment_F, i_segment_G};
  assign w_diff    = (w_pattern != r_sample);
  assign w_stable  = !w_diff && (r_count >= c_stable_thresh);

  // When w_stable is true, the live input equals r_sample.
  // The decoder therefore reads the registered copy.
  always_comb begin
    w_dec_num     = 4'd0;
    w_dec_invalid = 1'b0;
    w_dec_blank   = 1'b0;
    case (r_sample)
      7'h7E: w_dec_num = 4'h0;
      7'h30: w_dec_num = 4'h1;
      7'h6D: w_dec_num = 4'h2;
      7'h79: w_dec_num = 4'h3;
      7'h33: w_dec_num = 4'h4;
      7'h5B: w_dec_num = 4'h5;
      7'h5F: w_dec_num = 4'h6;
      7'h70: w_dec_num = 4'h7;
      7'h7F: w_dec_num = 4'h8;
      7'h7B: w_dec_num = 4'h9;
      7'h77: w_dec_num = 4'hA;
      7'h1F: w_dec_num = 4'hB;
      7'h4E: w_dec_num = 4'hC;
      7'h3D: w_dec_num = 4'hD;
      7'h4F: w_dec_num = 4'hE;
      7'h47: w_dec_num = 4'hF;
`ifdef SEG7_DEC_BLANK_EN
      7'h00: w_dec_blank = 1'b1;
`endif
      default: w_dec_invalid = 1'b1;
    endcase
  end

  // The sampler and counter run in every state.
  // This lets filtering of a new pattern overlap a result that is still
  // being presented.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sample <= 7'd0;
      r_count  <= 8'd0;
    end else begin
      r_sample <= w_pattern;
      if (w_diff)
        r_count <= 8'd0;
      else if (r_count != 8'hFF)
        r_count <= r_count + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_WAIT;
      r_last       <= 7'd0;
      r_emitted    <= 1'b0;
      r_changed    <= 1'b0;
      o_valid      <= 1'b0;
      o_binary_num <= 4'd0;
      o_invalid    <= 1'b0;
      o_blank      <= 1'b0;
    end else begin
      case (r_state)
        S_WAIT: begin
          if (w_stable && (!r_emitted || (r_sample != r_last))) begin
            r_state      <= S_VALID;
            o_valid      <= 1'b1;
            o_binary_num <= w_dec_num;
            o_invalid    <= w_dec_invalid;
            o_blank      <= w_dec_blank;
            r_last       <= r_sample;
            r_emitted    <= 1'b1;
            r_changed    <= 1'b0;
          end
        end
        S_VALID: begin
          if (i_ready) begin
            o_valid <= 1'b0;
            // A change seen on the transfer edge counts as a change.
            r_state <= (r_changed || w_diff) ? S_WAIT : S_LOCK;
          end else if (w_diff) begin
            r_changed <= 1'b1;
          end
        end
        S_LOCK: begin
          if (w_diff)
            r_state <= S_WAIT;
        end
        default: r_state <= S_WAIT;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_seg7_to_bin.sv
`default_nettype none
// ============================================================================
// Module      : tb_seg7_to_bin
// Description : Scoreboard testbench for seg7_to_bin (STABLE_CYCLES = 4).
//               Stimulus queues the expected results. A negedge monitor pops
//               and compares one entry on every valid/ready transfer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seg7_to_bin;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] pat;
  logic       ready;
  logic       valid;
  logic [3:0] bin;
  logic       inv;
  logic       blank;

  int n_checks = 0;
  int n_fail   = 0;

  logic [5:0] exp_q[$];   // {num[3:0], invalid, blank}

  always #5 clk = ~clk;

  seg7_to_bin #(.STABLE_CYCLES(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .i_segment_A  (pat[6]),
    .i_segment_B  (pat[5]),
    .i_segment_C  (pat[4]),
    .i_segment_D  (pat[3]),
    .i_segment_E  (pat[2]),
    .i_segment_F  (pat[1]),
    .i_segment_G  (pat[0]),
    .i_ready      (ready),
    .o_valid      (valid),
    .o_binary_num (bin),
    .o_invalid    (inv),
    .o_blank      (blank)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [3:0] num, input logic iv, input logic bl);
    exp_q.push_back({num, iv, bl});
  endtask

  // Monitor: a transfer happens at the next posedge when valid & ready hold.
  always @(negedge clk) begin
    if (!rst && valid && ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_result: got num=%0h inv=%0b blank=%0b expected none", bin, inv, blank);
      end else begin
        chk("scoreboard_result", {26'd0, bin, inv, blank}, {26'd0, exp_q.pop_front()});
      end
    end
  end

  initial begin
    rst   = 1'b1;
    pat   = 7'h00;
    ready = 1'b1;
    tick(3);
    chk("reset_valid",   valid, 0);
    chk("reset_binary",  bin,   0);
    chk("reset_invalid", inv,   0);
    chk("reset_blank",   blank, 0);

    // Digit 2: o_valid must rise exactly on the 4th edge after capture.
    rst = 1'b0;
    pat = 7'h6D;
    push(4'h2, 1'b0, 1'b0);
    tick(1);                                  // capture edge k
    for (int i = 0; i < 3; i++) begin
      tick(1);
      chk("latency_low", valid, 0);
    end
    tick(1);                                  // edge k+4
    chk("latency_high", valid, 1);
    chk("first_binary", bin, 2);
    tick(1);                                  // transfer
    chk("pulse_drop", valid, 0);
    for (int i = 0; i < 6; i++) begin
      tick(1);
      chk("lock_no_repeat", valid, 0);
    end

    // 79 is only briefly stable before 30 replaces it. Only 1 is emitted.
    pat = 7'h79;
    tick(2);
    push(4'h1, 1'b0, 1'b0);
    pat = 7'h30;
    tick(8);

    // Digit 5, a one-cycle glitch to 8, then a return to 5: no duplicate 5.
    push(4'h5, 1'b0, 1'b0);
    pat = 7'h5B;
    tick(8);
    pat = 7'h7F;
    tick(1);
    pat = 7'h5B;
    tick(8);
    chk("glitch_suppressed", valid, 0);
    push(4'h8, 1'b0, 1'b0);
    pat = 7'h7F;
    tick(8);

    // Back-pressure: E stays presented while the input moves to F.
    ready = 1'b0;
    push(4'hE, 1'b0, 1'b0);
    pat = 7'h4F;
    tick(6);
    chk("held_valid", valid, 1);
    pat = 7'h47;
    tick(10);
    chk("held_valid2", valid, 1);
    chk("held_binary", bin, 4'hE);
    push(4'hF, 1'b0, 1'b0);
    ready = 1'b1;
    tick(8);

    // Illegal pattern, then the all-off pattern.
    push(4'h0, 1'b1, 1'b0);
    pat = 7'h01;
    tick(8);
`ifdef SEG7_DEC_BLANK_EN
    push(4'h0, 1'b0, 1'b1);
`else
    push(4'h0, 1'b1, 1'b0);
`endif
    pat = 7'h00;
    tick(8);

    // Reset during presentation discards the result. The result is then
    // emitted again after release.
    ready = 1'b0;
    pat   = 7'h33;
    tick(6);
    chk("pre_reset_valid", valid, 1);
    chk("pre_reset_binary", bin, 4);
    rst   = 1'b1;
    ready = 1'b1;
    tick(1);
    chk("reset_drops_valid", valid, 0);
    chk("reset_clears_binary", bin, 0);
    rst = 1'b0;
    push(4'h4, 1'b0, 1'b0);
    for (int i = 0; i < 12 && !valid; i++) tick(1);
    chk("reemit_after_reset", valid, 1);
    tick(6);

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/seg7_to_bin.md
SEG7_TO_BIN -- requirements
Module: seg7_to_bin

Interface
REQ-001 Parameter STABLE_CYCLES, default 4, consecutive clk edges a segment pattern must be constant before it is accepted; legal range 1..255.
REQ-002 clk  input  1  system clock; all logic on rising edge.
REQ-003 rst  input  1  synchronous reset, active-high.
REQ-004 i_segment_A .. i_segment_G  input  1 each  segment lines, active-high; pattern bit order {A,B,C,D,E,F,G} = bits 6..0.
REQ-005 i_ready  input  1  downstream accepts the current result.
REQ-006 o_valid  output  1  result held and available.
REQ-007 o_binary_num  output  4  decoded value.
REQ-008 o_invalid  output  1  accepted pattern is not a legal glyph.
REQ-009 o_blank  output  1  accepted pattern is all-off (SEG7_DEC_BLANK_EN only).

Function
REQ-010 Legal glyph table (value:pattern hex) SHALL be 0:7E 1:30 2:6D 3:79 4:33 5:5B 6:5F 7:70 8:7F 9:7B A:77 B:1F C:4E D:3D E:4F F:47.
REQ-011 Input pattern SHALL be registered every cycle; 8-bit saturating stability counter clears when input differs from registered sample, else increments.
REQ-012 Pattern applied before edge k and held SHALL raise o_valid after edge k+STABLE_CYCLES (filter latency exactly STABLE_CYCLES cycles).
REQ-013 FSM states: S_WAIT (filtering), S_VALID (result presented), S_LOCK (result consumed, awaiting change).
REQ-014 S_WAIT -> S_VALID when pattern stable and differs from last emitted pattern, or no pattern emitted since reset.
REQ-015 S_WAIT stays in S_WAIT when stable pattern equals last emitted pattern (glitch-and-return suppressed, no duplicate output).
REQ-016 S_VALID: o_valid=1; o_binary_num, o_invalid, o_blank frozen until transfer (o_valid & i_ready at an edge).
REQ-017 Transfer SHALL drop o_valid on the following cycle; next state S_WAIT if input changed during S_VALID, else S_LOCK.
REQ-018 S_LOCK -> S_WAIT on any input change vs registered sample; counter restarts from 0.
REQ-019 Illegal pattern: o_invalid=1, o_binary_num=0, still presented via valid/ready and recorded as last emitted.
REQ-020 Legal pattern: o_invalid=0, o_binary_num = table value.
REQ-021 i_ready while o_valid=0 SHALL have no effect.
REQ-022 Input changes during S_VALID SHALL NOT alter presented outputs; filtering of new pattern begins in parallel, counted from the change.

Reset
REQ-023 rst at an edge SHALL force S_WAIT, o_valid=0, o_binary_num=0, o_invalid=0, o_blank=0, counter=0, sample=0, "emitted" flag cleared; overrides in-flight result and any concurrent i_ready.
REQ-024 Reset mid-S_VALID SHALL discard the result; same held pattern re-emitted STABLE_CYCLES cycles after rst deasserts.

Configuration
REQ-025 Macro SEG7_DEC_BLANK_EN defined: pattern 00 is legal, reported o_blank=1, o_invalid=0, o_binary_num=0.
REQ-026 SEG7_DEC_BLANK_EN undefined: pattern 00 reported o_invalid=1; o_blank port present, tied 0.

Verification (STABLE_CYCLES=4)
REQ-027 Reset, apply 6D held, i_ready=1 -> o_valid high exactly after 4th edge, o_binary_num=2, one-cycle pulse, then S_LOCK (no repeat).
REQ-028 Apply 79, toggle to 30 after 2 cycles, hold 30 -> single result o_binary_num=1; 3 never emitted.
REQ-029 Emit 5B, glitch to 7F for 1 cycle, return to 5B -> no second result; then 7F held 4 cycles -> o_binary_num=8.
REQ-030 Apply 4F with i_ready=0 for 10 cycles while input moves to 47 -> outputs hold E; ready pulse -> E accepted, then F emitted after 4 stable cycles.
REQ-031 Apply 01 -> o_invalid=1, o_binary_num=0; apply 00 -> o_blank=1 with SEG7_DEC_BLANK_EN, o_invalid=1 without.
REQ-032 rst asserted during S_VALID with i_ready=1 -> o_valid=0 next cycle, no transfer; held pattern re-emitted 4 cycles after release.
